// File: rtl/lb_rot_sched_pkg.sv
// Shared types for the 3x3 window line-buffer path.
// Buffer indices are shared with the rotating read counter.
package lb_rot_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_STREAM,
        S_DRAIN,
        S_DONE_WAIT
    } lb_state_e;

    localparam int NUM_LB   = 4;
    localparam int WIN_ROWS = 3;

    typedef logic [1:0] lb_idx_t;

endpackage

// File: rtl/lb_pos_cnt.sv
// Column/row position counter with wrap and last-row flags.
// Column wraps at COLS-1, row wraps after ROWS-1.
module lb_pos_cnt #(
    parameter int COLS = 32,
    parameter int ROWS = 32,
    parameter int CW   = 5,
    parameter int RW   = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] row_o,
    output logic          wrap_o,
    output logic          last_row_o
);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          col_end;

    assign col_end    = (col_q == CW'(COLS - 1));
    assign wrap_o     = en_i && col_end;
    assign last_row_o = (row_q == RW'(ROWS - 1));
    assign col_o      = col_q;
    assign row_o      = row_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr_i) begin
            col_d = '0;
            row_d = '0;
        end else if (en_i) begin
            if (col_end) begin
                col_d = '0;
                row_d = last_row_o ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/lb_rot_sched.sv
// Sequencer for a 4-entry rotating line-buffer bank feeding
// the 3x3 window: fill, lockstep stream, drain, done.
module lb_rot_sched
    import lb_rot_sched_pkg::*;
#(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int CW    = $clog2(IMG_W),
    parameter int RW    = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          win_ready,
    output logic          wr_en,
    output logic [1:0]    wr_buf,
    output logic [CW-1:0] wr_addr,
    output logic          rd_en,
    output logic [1:0]    rd_base,
    output logic [CW-1:0] rd_addr,
    output logic          win_valid,
    output logic [CW-1:0] win_col,
    output logic [RW-1:0] win_row,
    output logic          busy,
    output logic          done
);

    lb_state_e     state_q;
    lb_idx_t       wr_buf_q;
    logic          win_valid_q, done_q;
    logic [CW-1:0] win_col_q;
    logic [RW-1:0] win_row_q;

    logic          start_go, in_xfer, drain_rd;
    logic [CW-1:0] in_col, out_col;
    logic [RW-1:0] in_row, out_row;
    logic          in_wrap, in_last, out_wrap, out_last;

    always_comb begin
        in_ready = 1'b0;
        drain_rd = 1'b0;
        unique case (state_q)
            S_FILL:   in_ready = 1'b1;
            S_STREAM: in_ready = win_ready;
            S_DRAIN:  drain_rd = win_ready;
            default:  ;
        endcase
    end

    assign start_go = (state_q == S_IDLE) && start;
    assign in_xfer  = in_valid && in_ready;
    assign wr_en    = in_xfer;
    assign rd_en    = drain_rd || ((state_q == S_STREAM) && in_xfer);
    assign wr_buf   = wr_buf_q;
    assign rd_base  = wr_buf_q + 2'd1;
    assign wr_addr  = in_col;
    // Reads track writes column-for-column while streaming.
    assign rd_addr  = out_col;
    assign win_valid = win_valid_q;
    assign win_col  = win_col_q;
    assign win_row  = win_row_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;

    lb_pos_cnt #(
        .COLS(IMG_W), .ROWS(IMG_H), .CW(CW), .RW(RW)
    ) u_in_cnt (
        .clk(clk), .rst_n(rst_n),
        .clr_i(start_go), .en_i(in_xfer),
        .col_o(in_col), .row_o(in_row),
        .wrap_o(in_wrap), .last_row_o(in_last)
    );

    lb_pos_cnt #(
        .COLS(IMG_W), .ROWS(IMG_H - 2), .CW(CW), .RW(RW)
    ) u_out_cnt (
        .clk(clk), .rst_n(rst_n),
        .clr_i(start_go), .en_i(rd_en),
        .col_o(out_col), .row_o(out_row),
        .wrap_o(out_wrap), .last_row_o(out_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_buf_q    <= '0;
            win_valid_q <= 1'b0;
            done_q      <= 1'b0;
            win_col_q   <= '0;
            win_row_q   <= '0;
        end else begin
            win_valid_q <= rd_en;
            done_q      <= 1'b0;
            if (rd_en) begin
                win_col_q <= out_col;
                win_row_q <= out_row;
            end
            if (start_go) begin
                wr_buf_q <= '0;
            end else if (in_wrap) begin
                wr_buf_q <= wr_buf_q + 2'd1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (start) state_q <= S_FILL;
                end
                S_FILL: begin
                    if (in_wrap && in_row == RW'(WIN_ROWS - 1))
                        state_q <= (IMG_H == WIN_ROWS) ? S_DRAIN : S_STREAM;
                end
                S_STREAM: begin
                    if (in_wrap && in_last) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (out_wrap && out_last) begin
                        state_q <= S_DONE_WAIT;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE_WAIT: state_q <= S_IDLE;
                default:     state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lb_rot_sched.sv
// Bench for lb_rot_sched: 4x5 frames vs a reference model,
// plus a cycle table for a 2x3 frame.
module tb_lb_rot_sched;

    localparam int W = 4;
    localparam int H = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start, in_valid, win_ready;
    logic       in_ready, wr_en, rd_en, win_valid, busy, done;
    logic [1:0] wr_buf, rd_base, wr_addr, rd_addr, win_col;
    logic [2:0] win_row;

    logic       s_start, s_in_valid, s_win_ready;
    logic       s_in_ready, s_wr_en, s_rd_en, s_win_valid, s_busy, s_done;
    logic [1:0] s_wr_buf, s_rd_base, s_win_row;
    logic [0:0] s_wr_addr, s_rd_addr, s_win_col;

    lb_rot_sched #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .win_ready(win_ready), .wr_en(wr_en), .wr_buf(wr_buf),
        .wr_addr(wr_addr), .rd_en(rd_en), .rd_base(rd_base),
        .rd_addr(rd_addr), .win_valid(win_valid),
        .win_col(win_col), .win_row(win_row),
        .busy(busy), .done(done)
    );

    lb_rot_sched #(.IMG_W(2), .IMG_H(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .win_ready(s_win_ready), .wr_en(s_wr_en), .wr_buf(s_wr_buf),
        .wr_addr(s_wr_addr), .rd_en(s_rd_en), .rd_base(s_rd_base),
        .rd_addr(s_rd_addr), .win_valid(s_win_valid),
        .win_col(s_win_col), .win_row(s_win_row),
        .busy(s_busy), .done(s_done)
    );

    int checks = 0;
    int errors = 0;
    int wq[$], rq[$], oq[$], ref_oq[$], ref_rq[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_opt(input string name, input int act, input int exp);
        if (exp >= 0) chk(name, act, exp);
    endtask

    // Per-cycle observation of the big instance.
    task automatic sample();
        chk("hs_wr", int'(wr_en), int'(in_valid && in_ready));
        if (wr_en) wq.push_back(int'(wr_buf) * 16 + int'(wr_addr));
        if (rd_en) begin
            chk("rd_gate", int'(win_ready), 1);
            rq.push_back(int'(rd_base) * 16 + int'(rd_addr));
        end
        if (done) chk("done_wv", int'(win_valid), 1);
        if (win_valid)
            oq.push_back(int'(done) * 256 + int'(win_row) * 16 + int'(win_col));
    endtask

    // Reference: row r lives in buffer r%4; window row o reads
    // rows o..o+2 so its oldest buffer (rd_base) is o%4.
    task automatic check_frame();
        int k;
        chk("n_wr", wq.size(), H * W);
        chk("n_rd", rq.size(), (H - 2) * W);
        chk("n_win", oq.size(), (H - 2) * W);
        k = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if (k < wq.size()) chk("wr_seq", wq[k], (r % 4) * 16 + c);
                k++;
            end
        k = 0;
        for (int o = 0; o < H - 2; o++)
            for (int c = 0; c < W; c++) begin
                if (k < rq.size()) chk("rd_seq", rq[k], (o % 4) * 16 + c);
                if (k < oq.size())
                    chk("win_seq", oq[k],
                        ((o == H - 3 && c == W - 1) ? 256 : 0) + o * 16 + c);
                k++;
            end
    endtask

    // mode 0 clean, 1 stall, 2 fill gaps, 3 random,
    // 4 start while busy, 5 reset mid-drain
    task automatic run_frame(input int mode);
        bit fin = 0;
        bit aborted = 0;
        int stall_n = 0;
        wq.delete(); rq.delete(); oq.delete();
        for (int cyc = 0; cyc < 500 && !fin && !aborted; cyc++) begin
            @(negedge clk);
            start = (cyc == 0) || (mode == 4 && cyc == 5);
            in_valid = 1'b1;
            win_ready = 1'b1;
            if (mode == 1 && wq.size() == 14 && stall_n < 3) begin
                win_ready = 1'b0;
                stall_n++;
            end
            if (mode == 2 && wq.size() < 12) in_valid = cyc[0];
            if (mode == 3) begin
                in_valid = ($urandom_range(0, 3) != 0);
                win_ready = ($urandom_range(0, 3) != 0);
            end
            #1;
            if (cyc == 0) chk("idle_at_start", int'(busy), 0);
            if (mode == 1 && !win_ready) begin
                chk("stall_rdy", int'(in_ready), 0);
                chk("stall_wr", int'(wr_en), 0);
                chk("stall_rd", int'(rd_en), 0);
                chk("stall_col", int'(wr_addr), 2);
            end
            if (mode == 5 && rq.size() == 9 && rd_en) begin
                chk("abort_col", int'(rd_addr), 1);
                rst_n = 1'b0;
                #1;
                chk("abort_busy", int'(busy), 0);
                chk("abort_wv", int'(win_valid), 0);
                chk("abort_rd", int'(rd_en), 0);
                chk("abort_wr", int'(wr_en), 0);
                rst_n = 1'b1;
                aborted = 1;
            end else begin
                sample();
                if (done) fin = 1;
            end
        end
        if (!aborted) begin
            if (!fin) chk("frame_timeout", 0, 1);
            else check_frame();
        end
    endtask

    typedef struct {
        int st, iv, wr;
        int busy, rdy, we, wb, wa, re, rb, ra, wv, wc, wrow, dn;
    } vec_t;
    vec_t vt[13];

    initial begin
        start = 0; in_valid = 0; win_ready = 0;
        s_start = 0; s_in_valid = 0; s_win_ready = 0;
        // IMG_W=2, IMG_H=3: fill with one gap, no stream, drain
        vt[0]  = '{1,1,1, 0,0,0,-1,-1, 0,-1,-1, 0,-1,-1, 0};
        vt[1]  = '{0,1,1, 1,1,1, 0, 0, 0,-1,-1, 0,-1,-1, 0};
        vt[2]  = '{0,1,1, 1,1,1, 0, 1, 0,-1,-1, 0,-1,-1, 0};
        vt[3]  = '{0,0,1, 1,1,0, 1,-1, 0,-1,-1, 0,-1,-1, 0};
        vt[4]  = '{0,1,1, 1,1,1, 1, 0, 0,-1,-1, 0,-1,-1, 0};
        vt[5]  = '{0,1,1, 1,1,1, 1, 1, 0,-1,-1, 0,-1,-1, 0};
        vt[6]  = '{0,1,1, 1,1,1, 2, 0, 0,-1,-1, 0,-1,-1, 0};
        vt[7]  = '{0,1,1, 1,1,1, 2, 1, 0,-1,-1, 0,-1,-1, 0};
        vt[8]  = '{0,1,1, 1,0,0, 3,-1, 1, 0, 0, 0,-1,-1, 0};
        vt[9]  = '{0,1,0, 1,0,0, 3,-1, 0,-1,-1, 1, 0, 0, 0};
        vt[10] = '{1,1,1, 1,0,0, 3,-1, 1, 0, 1, 0,-1,-1, 0};
        vt[11] = '{0,1,1, 1,0,0, 3,-1, 0,-1,-1, 1, 1, 0, 1};
        vt[12] = '{0,1,1, 0,0,0,-1,-1, 0,-1,-1, 0,-1,-1, 0};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_wv", int'(win_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rdy", int'(in_ready), 0);
        chk("rst_wr", int'(wr_en), 0);
        chk("rst_buf", int'(wr_buf), 0);

        foreach (vt[i]) begin
            @(negedge clk);
            s_start = vt[i].st[0];
            s_in_valid = vt[i].iv[0];
            s_win_ready = vt[i].wr[0];
            #1;
            chk_opt("s_busy", int'(s_busy), vt[i].busy);
            chk_opt("s_rdy", int'(s_in_ready), vt[i].rdy);
            chk_opt("s_we", int'(s_wr_en), vt[i].we);
            chk_opt("s_wbuf", int'(s_wr_buf), vt[i].wb);
            chk_opt("s_waddr", int'(s_wr_addr), vt[i].wa);
            chk_opt("s_re", int'(s_rd_en), vt[i].re);
            chk_opt("s_rbase", int'(s_rd_base), vt[i].rb);
            chk_opt("s_raddr", int'(s_rd_addr), vt[i].ra);
            chk_opt("s_wv", int'(s_win_valid), vt[i].wv);
            chk_opt("s_wcol", int'(s_win_col), vt[i].wc);
            chk_opt("s_wrow", int'(s_win_row), vt[i].wrow);
            chk_opt("s_done", int'(s_done), vt[i].dn);
        end
        s_start = 0;

        run_frame(0);
        ref_oq = oq;
        ref_rq = rq;
        run_frame(4);
        chk("b2b_len", oq.size(), ref_oq.size());
        foreach (ref_oq[i])
            if (i < oq.size()) chk("b2b_win", oq[i], ref_oq[i]);
        foreach (ref_rq[i])
            if (i < rq.size()) chk("b2b_rd", rq[i], ref_rq[i]);
        run_frame(1);
        run_frame(2);
        run_frame(5);
        run_frame(0);
        repeat (4) run_frame(3);

        @(negedge clk);
        start = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lb_rot_sched.md
Name: lb_rot_sched

Overview:
- Sequences a 4-entry rotating line-buffer bank for the 3x3 convolution window path.
- Streams incoming pixels row by row into one "write" buffer, and in lockstep reads the same column from the other three.
- Emits the 2-bit rotation base that the rotating counter expands into three buffer indices, in oldest-first order.
- Handles initial fill, steady-state streaming, final drain and completion.

Parameters:
- IMG_W, 32, pixels per row (>=2)
- IMG_H, 32, rows per frame (>=3)
- CW, $clog2(IMG_W), column counter width (derived)
- RW, $clog2(IMG_H), row counter width (derived)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame start pulse; honoured only in IDLE
- in_valid  in  1  input pixel valid
- in_ready  out  1  input pixel accepted when in_valid && in_ready
- win_ready  in  1  consumer will accept a window column delivered next cycle
- wr_en  out  1  line-buffer write strobe
- wr_buf  out  2  buffer index being written
- wr_addr  out  CW  write column
- rd_en  out  1  line-buffer read strobe (synchronous RAM, 1-cycle latency)
- rd_base  out  2  rotation base to the rotating counter, = wr_buf+1 mod 4
- rd_addr  out  CW  read column
- win_valid  out  1  window column data valid on RAM outputs (registered rd_en)
- win_col  out  CW  column of the current window output
- win_row  out  RW  output row index, 0..IMG_H-3
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse coincident with the last win_valid

Behaviour:
- States:
  - IDLE: start -> FILL.
  - FILL: accept rows 0..2. After the last pixel of row 2 -> STREAM.
  - STREAM: rows 3..IMG_H-1. After the last pixel of row IMG_H-1 -> DRAIN.
  - DRAIN: no input; issues IMG_W reads. After the last read -> DONE_WAIT.
  - DONE_WAIT: lasts one cycle, while the final win_valid and done are high; then -> IDLE.
- Reset (async): state=IDLE; wr_buf=0; all counters 0; win_valid=0; done=0; busy=0. Reset mid-frame aborts immediately, with no further writes or reads.
- in_ready: 1 in FILL; win_ready in STREAM; 0 otherwise.
- FILL:
  - Each accepted pixel asserts wr_en combinationally, with wr_addr=col.
  - No reads.
- STREAM:
  - Each accepted pixel asserts wr_en and rd_en in the same cycle.
  - wr_addr=rd_addr=col; rd_base=wr_buf+1.
- DRAIN:
  - rd_en = win_ready, with rd_addr=col.
  - No writes; wr_buf holds IMG_H mod 4.
- Column and row advance:
  - col increments on each accepted or issued transfer.
  - At IMG_W-1, col wraps to 0, wr_buf increments mod 4 (wraps 3->0), and the input row counter increments.
- Window outputs:
  - win_valid is rd_en delayed 1 cycle.
  - win_col and win_row are the registered read column and output row.
  - Output row increments at each read-column wrap.
- Backpressure: win_ready low stalls both input and reads in STREAM. FILL is never stalled by win_ready.
- start while busy is ignored. in_valid in IDLE, DRAIN or DONE_WAIT is ignored (in_ready=0).
- Total window columns per frame: (IMG_H-2)*IMG_W. Total writes: IMG_H*IMG_W.
- Back-to-back frames: start is accepted in IDLE on the cycle after done. wr_buf resets to 0 at each start.

Decomposition:
- Shared conv package holds:
  - state typedef (IDLE, FILL, STREAM, DRAIN, DONE_WAIT);
  - NUM_LB=4 and WIN_ROWS=3 constants;
  - a 2-bit buffer-index typedef shared with the rotating counter.
- One natural sub-module, lb_pos_cnt: col/row counter with enable, wrap flag and last-row flag.
  - Instantiated twice: input side and output side.

Test Plan (IMG_W=4, IMG_H=5 unless stated):
- Reset, then start with in_valid held high and win_ready=1:
  - 12 FILL writes with wr_buf sequence 0,0,0,0,1,...,2.
  - STREAM row 3: wr_buf=3, rd_base=0.
  - STREAM row 4: wr_buf=0, rd_base=1.
  - DRAIN: rd_base=2.
  - 12 win_valid total, win_row 0,1,2.
  - done asserted with the 12th win_valid.
- win_ready low for 3 cycles mid STREAM row 3 at col 2:
  - in_ready=0, no wr_en/rd_en, col holds 2.
  - Resumes with identical addresses; total counts unchanged.
- in_valid gaps of 1 cycle every other pixel in FILL: writes occur only on handshake cycles; wr_addr has no skips.
- rst_n asserted low during DRAIN at col 1:
  - Immediately state=IDLE, busy=0, win_valid=0.
  - A new start produces a full correct frame from wr_buf=0.
- start pulsed while busy (cycle 5): ignored, and the frame completes normally. Two frames back-to-back yield identical output sequences.
- IMG_H=3, IMG_W=2: FILL of 6 writes, STREAM skipped, DRAIN with rd_base=0, 2 win_valid, done.
